// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the contact-bounce emulator.
// The LFSR is a 16-bit Galois generator; each channel keeps a 16-bit window count.
package bounce_gen_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    BOUNCE = 1'b1
  } bounce_state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          LFSR_W    = 16;
  localparam int          WIN_W     = 16;

endpackage

// File: rtl/bounce_channel.sv
// One bounce channel: tracks the accepted clean level and, for a window after
// each accepted change, toggles its output at pseudo-random gaps before settling.
module bounce_channel
  import bounce_gen_pkg::*;
#(
  parameter int BOUNCE_CYCLES = 1000,
  parameter int GAP_BITS      = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              En,
  input  logic              in,
  input  logic [GAP_BITS:0] gap_seed,
  output logic              out,
  output logic              busy
);

  localparam logic [WIN_W-1:0]  WIN_LOAD = WIN_W'(BOUNCE_CYCLES - 1);
  localparam logic [GAP_BITS:0] GAP_ONE  = (GAP_BITS + 1)'(1);

  bounce_state_e     state_q;
  logic              tgt_q;
  logic              out_q;
  logic              busy_q;
  logic [WIN_W-1:0]  win_q;
  logic [GAP_BITS:0] gap_q;

  // A mismatch between the clean input and the accepted level (re)starts a
  // window in either state; the first contact is always the new level.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      tgt_q   <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      win_q   <= '0;
      gap_q   <= '0;
    end else if (!En) begin
      state_q <= IDLE;
      tgt_q   <= in;
      out_q   <= in;
      busy_q  <= 1'b0;
    end else if (in != tgt_q) begin
      state_q <= BOUNCE;
      tgt_q   <= in;
      out_q   <= in;
      busy_q  <= 1'b1;
      win_q   <= WIN_LOAD;
      gap_q   <= gap_seed;
    end else begin
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
        end
        BOUNCE: begin
          if (win_q == '0) begin
            // Settle wins over a toggle falling on the same cycle.
            state_q <= IDLE;
            out_q   <= tgt_q;
            busy_q  <= 1'b0;
          end else begin
            win_q <= win_q - 1'b1;
            if (gap_q == GAP_ONE) begin
              out_q <= ~out_q;
              gap_q <= gap_seed;
            end else begin
              gap_q <= gap_q - 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out  = out_q;
  assign busy = busy_q;

endmodule

// File: rtl/bounce_generator.sv
// N-channel switch-bounce emulator: clean levels in, bouncing levels out.
// One free-running LFSR supplies every channel's toggle gap from its own bit slice.
module bounce_generator
  import bounce_gen_pkg::*;
#(
  parameter int          N             = 4,
  parameter int          BOUNCE_CYCLES = 1000,
  parameter int          GAP_BITS      = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         En,
  input  logic [N-1:0] Input,
  output logic [N-1:0] Output,
  output logic [N-1:0] Busy
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_d = (lfsr_q >> 1) ^ LFSR_TAPS;
  end

  // Runs regardless of En so gap sequences never stall.
  always_ff @(posedge Clk) begin
    if (Rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [GAP_BITS:0] gap_seed;
    assign gap_seed = {1'b0, lfsr_q[GAP_BITS*i +: GAP_BITS]} + (GAP_BITS + 1)'(1);

    bounce_channel #(
      .BOUNCE_CYCLES (BOUNCE_CYCLES),
      .GAP_BITS      (GAP_BITS)
    ) u_ch (
      .Clk      (Clk),
      .Rst      (Rst),
      .En       (En),
      .in       (Input[i]),
      .gap_seed (gap_seed),
      .out      (Output[i]),
      .busy     (Busy[i])
    );
  end

endmodule

// File: tb/tb_bounce_generator.sv
// Directed bench for bounce_generator with a 16-clock window and 2-bit gaps,
// so every window is guaranteed to contain at least one toggle.
module tb_bounce_generator;

  localparam int N  = 4;
  localparam int BC = 16;
  localparam int GB = 2;

  logic         Clk;
  logic         Rst;
  logic         En;
  logic [N-1:0] Input;
  logic [N-1:0] Output;
  logic [N-1:0] Busy;

  int n_cmp  = 0;
  int n_fail = 0;

  bounce_generator #(
    .N             (N),
    .BOUNCE_CYCLES (BC),
    .GAP_BITS      (GB),
    .LFSR_SEED     (16'hACE1)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .En     (En),
    .Input  (Input),
    .Output (Output),
    .Busy   (Busy)
  );

  // Clock / reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one rising edge; inputs are changed and outputs sampled 1ns later.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  initial begin
    logic [15:0] lfsr_m;
    logic        busy_ok;
    logic        quiet_ok;
    logic        prev;
    int          toggles;
    logic [N-1:0] val;
    logic [N-1:0] settled;

    // ---- Reset with Input high ----
    Rst = 1'b1; En = 1'b1; Input = 4'hF;
    step();
    check("reset_out_c1", 16'(Output), 16'h0);
    check("reset_busy_c1", 16'(Busy), 16'h0);
    Input = 4'h0;
    step();
    check("reset_out_c2", 16'(Output), 16'h0);
    check("reset_busy_c2", 16'(Busy), 16'h0);
    Rst = 1'b0;
    check("lfsr_seed", dut.lfsr_q, 16'hACE1);
    lfsr_m = 16'hACE1;
    for (int k = 0; k < 3; k++) begin
      step();
      lfsr_m = lfsr_next(lfsr_m);
    end
    check("lfsr_step3", dut.lfsr_q, lfsr_m);

    // ---- Single edge on channel 0 ----
    Input = 4'b0001;
    step();
    check("edge_first_contact", 16'(Output[0]), 16'h1);
    busy_ok = (Busy == 4'b0001);
    quiet_ok = (Output[3:1] == 3'b000);
    prev = Output[0];
    toggles = 0;
    for (int k = 2; k <= BC; k++) begin
      step();
      if (Busy != 4'b0001) busy_ok = 1'b0;
      if (Output[3:1] != 3'b000) quiet_ok = 1'b0;
      if (Output[0] != prev) toggles++;
      prev = Output[0];
    end
    check("edge_busy_window", 16'(busy_ok), 16'h1);
    check("edge_others_static", 16'(quiet_ok), 16'h1);
    check("edge_toggled", 16'(toggles > 0), 16'h1);
    step();
    check("edge_settle_out", 16'(Output), 16'h1);
    check("edge_settle_busy", 16'(Busy), 16'h0);

    // ---- Retarget on channel 1 ----
    Input = 4'b0011;
    step();
    for (int k = 2; k <= 5; k++) step();
    check("retgt_busy_before", 16'(Busy[1]), 16'h1);
    Input = 4'b0001;
    busy_ok = 1'b1;
    for (int k = 6; k <= 21; k++) begin
      step();
      if (Busy[1] !== 1'b1) busy_ok = 1'b0;
    end
    check("retgt_busy_extended", 16'(busy_ok), 16'h1);
    step();
    check("retgt_final_out", 16'(Output[1]), 16'h0);
    check("retgt_final_busy", 16'(Busy), 16'h0);

    // ---- Pass-through ----
    En = 1'b0;
    for (int k = 0; k < 6; k++) begin
      val = (k % 2 == 0) ? 4'h5 : 4'hA;
      Input = val;
      step();
      check("pass_out", 16'(Output), 16'(val));
      check("pass_busy", 16'(Busy), 16'h0);
    end

    // ---- Reset mid-window ----
    Input = 4'h0;
    step();
    En = 1'b1;
    step();
    check("en_rise_no_action", 16'(Busy), 16'h0);
    Input = 4'h4;
    step();
    for (int k = 2; k <= 7; k++) step();
    check("rst_abort_pre_busy", 16'(Busy), 16'h4);
    Rst = 1'b1;
    Input = 4'h0;
    step();
    check("rst_abort_out", 16'(Output), 16'h0);
    check("rst_abort_busy", 16'(Busy), 16'h0);
    Rst = 1'b0;
    step();

    // ---- En dropped mid-window ----
    Input = 4'h8;
    step();
    for (int k = 2; k <= 7; k++) step();
    check("en_abort_pre_busy", 16'(Busy), 16'h8);
    En = 1'b0;
    step();
    check("en_abort_out", 16'(Output), 16'h8);
    check("en_abort_busy", 16'(Busy), 16'h0);
    En = 1'b1;
    step();

    // ---- Short random soak: every change must settle to the clean level ----
    settled = 4'h8;
    for (int r = 0; r < 12; r++) begin
      val = 4'($urandom_range(0, 15));
      Input = val;
      for (int k = 0; k <= BC; k++) step();
      check("soak_out", 16'(Output), 16'(val));
      check("soak_busy", 16'(Busy), 16'h0);
      quiet_ok = 1'b1;
      for (int k = 0; k < 3; k++) begin
        step();
        if (Output != val || Busy != 4'h0) quiet_ok = 1'b0;
      end
      check("soak_no_spurious", 16'(quiet_ok), 16'h1);
      settled = val;
    end
    check("soak_last_level", 16'(Output), 16'(settled));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bounce_generator.md
Name: bounce_generator

Overview:
- Emulates mechanical switch contact bounce: clean, synchronous per-channel levels in; realistically bouncing levels out.
- Inverse of the board's debouncer. Used for on-chip loopback self-test (generator -> debouncer -> compare) and as a bench stimulus source.
- N independent channels share one free-running LFSR that sets pseudo-random toggle gaps.

Parameters:
- N, 4, number of channels.
- BOUNCE_CYCLES, 1000, bounce window length in clocks; legal range 2..65535.
- GAP_BITS, 4, LFSR bits per channel; toggle gap is 1..2^GAP_BITS clocks. Constraint: N*GAP_BITS <= 16.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  synchronous, active-high reset.
- En  in  1  1 = bounce emulation on; 0 = pass-through.
- Input  in  N  clean levels, synchronous to Clk.
- Output  out  N  emulated bouncing levels, registered.
- Busy  out  N  per channel, 1 while that channel is in BOUNCE.

Behaviour:
- Reset (Rst=1 at a rising edge): Output=0, Busy=0, tgt=0, all channels IDLE, win=0, gap=0, LFSR=LFSR_SEED. Rst overrides all other inputs. Reset during BOUNCE aborts the window immediately.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11 (mask 16'hB400). Advances every cycle when not in reset, regardless of En. Channel i gap value = LFSR[GAP_BITS*i +: GAP_BITS] + 1.
- Per-channel registers:
  - tgt: last accepted clean level.
  - win: window counter, 16 bits.
  - gap: toggle counter, GAP_BITS+1 bits.
  - state: IDLE or BOUNCE.
- En=0:
  - Output <= Input and tgt <= Input each cycle (1-cycle latency).
  - state forced to IDLE; Busy=0.
- IDLE, En=1:
  - If Input[i] != tgt[i] (edge): tgt <= Input[i]; Output[i] <= Input[i] (first contact); win <= BOUNCE_CYCLES-1; gap <= gap value; state <= BOUNCE.
  - Otherwise hold; Output[i] == tgt[i] holds invariantly.
- BOUNCE, evaluated in strict priority:
  1. Retarget: if Input[i] != tgt[i], do the same actions as an IDLE edge. Window restarts; there is no cap on how often this can happen.
  2. Settle: else if win==0, then Output <= tgt and state <= IDLE. Settle takes precedence over a toggle in the same cycle.
  3. Else: win <= win-1.
     - If gap==1: Output <= ~Output; gap reloads from the current gap value.
     - Otherwise gap <= gap-1.
- Busy[i] = (state==BOUNCE), registered with state.
- Latency: Busy is high for exactly BOUNCE_CYCLES clocks after the last accepted Input change. Output equals tgt from the following edge onward.
- Simultaneous edges on several channels are fully independent; there is no cross-channel interaction other than the shared LFSR.
- En falling mid-BOUNCE: next edge gives Output=Input, IDLE, Busy=0.
- En rising: no action until the next Input/tgt mismatch.

Decomposition:
- Package bounce_gen_pkg holds:
  - state enum (IDLE=1'b0, BOUNCE=1'b1)
  - LFSR_TAPS = 16'hB400
  - LFSR_W = 16
  - WIN_W = 16
- Sub-module bounce_channel holds one channel's FSM, tgt, win and gap. Its inputs are Clk, Rst, En, in, gap_seed; its outputs are out and busy.
- Top instantiates the LFSR inline and generates N bounce_channel instances.

Test Plan:
- Reset: assert Rst 2 cycles with Input=4'hF -> Output=0, Busy=0 during reset. LFSR state reads 16'hACE1 on the first post-reset cycle.
- Single edge (BOUNCE_CYCLES=16, En=1): Input[0] 0->1 at edge t.
  - Output[0]=1 at t+1; Busy[0]=1 for cycles t+1..t+16.
  - Output[0] toggles at least once inside the window.
  - Output[0]=1 and Busy[0]=0 from t+17; other channels are static.
- Retarget (BOUNCE_CYCLES=16): Input[1] 0->1 at t, then 1->0 at t+5.
  - Busy[1] stays high through t+21.
  - Final Output[1]=0 and Busy[1]=0 at t+22.
- Pass-through: En=0, Input toggles every cycle with pattern 4'h5/4'hA -> Output equals Input delayed 1 cycle; Busy=0 throughout.
- Mid-window abort:
  - Rst asserted at t+8 of a window -> Output=0, Busy=0 next cycle.
  - Separately, En dropped at t+8 -> Output=Input, Busy=0 next cycle.
- Loopback soak: generator feeding the debouncer, 10^5 random clean toggles spaced > BOUNCE_CYCLES+debounce time -> debouncer output equals Input delayed, with zero spurious edges.
